// File: rtl/tictactoe_board_ctrl_if.sv
// ---------------------------------------------------------------------------
// tictactoe_board_ctrl_if
// Move-request / board-state bundle for the TicTacToe board controller.
//   master : move source side (drives new_game, move_valid, move_num)
//   slave  : board controller (drives ready/turn flags, pos1..pos9,
//            illegal_move, game_over, winner, move_count)
// ---------------------------------------------------------------------------
interface tictactoe_board_ctrl_if;
    logic       new_game;
    logic       move_valid;
    logic [3:0] move_num;
    logic       move_ready;
    logic       player_play;
    logic       computer_play;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    logic       illegal_move;
    logic       game_over;
    logic [1:0] winner;
    logic [3:0] move_count;

    modport master (
        output new_game, move_valid, move_num,
        input  move_ready, player_play, computer_play,
        input  pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
        input  illegal_move, game_over, winner, move_count
    );

    modport slave (
        input  new_game, move_valid, move_num,
        output move_ready, player_play, computer_play,
        output pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
        output illegal_move, game_over, winner, move_count
    );
endinterface

// File: rtl/tictactoe_board_ctrl.sv
// ---------------------------------------------------------------------------
// tictactoe_board_ctrl
// Owns the nine TicTacToe squares: validates move requests (1..9, empty
// target), commits legal moves, alternates turns and detects win / draw
// one cycle after each commit.
// Ports:
//   clk    : clock, all state on rising edge
//   reset  : asynchronous, active-high
//   bus    : tictactoe_board_ctrl_if.slave (move request in, board/status out)
// Optional feature macro: TTT_ALT_START_EN -- opening side alternates on
// every new_game (first new_game after reset opens with the computer).
// ---------------------------------------------------------------------------
module tictactoe_board_ctrl #(
    parameter logic [1:0] PLAYER_CODE   = 2'b01,
    parameter logic [1:0] COMPUTER_CODE = 2'b10
) (
    input  logic                   clk,
    input  logic                   reset,
    tictactoe_board_ctrl_if.slave  bus
);
    localparam int unsigned SQUARES = 9;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {PLAYER_TURN, COMPUTER_TURN, CHECK, DONE} state_t;

    state_t             r_state, w_state_nxt, w_start_state;
    logic [1:0]         r_board [SQUARES];
    logic [1:0]         w_board_nxt [SQUARES];
    logic [CNT_W-1:0]   r_count, w_count_nxt;
    logic [1:0]         r_winner, w_winner_nxt;
    logic               r_game_over, w_game_over_nxt;
    logic               r_illegal, w_illegal_nxt;
    logic               r_mover_comp, w_mover_comp_nxt;
    logic               r_move_ready, r_player_play, r_computer_play;
    logic               w_in_range, w_win;
    logic [CNT_W-1:0]   w_idx;
    logic [1:0]         w_target;

`ifdef TTT_ALT_START_EN
    // Set at reset so the first new_game opens with the computer.
    logic r_alt_comp;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)             r_alt_comp <= 1'b1;
        else if (bus.new_game) r_alt_comp <= ~r_alt_comp;
    end
    assign w_start_state = r_alt_comp ? COMPUTER_TURN : PLAYER_TURN;
`else
    assign w_start_state = PLAYER_TURN;
`endif

    function automatic logic line3(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        return (a != 2'b00) && (a == b) && (b == c);
    endfunction

    // Three rows, three columns, two diagonals.
    assign w_win = line3(r_board[0], r_board[1], r_board[2]) |
                   line3(r_board[3], r_board[4], r_board[5]) |
                   line3(r_board[6], r_board[7], r_board[8]) |
                   line3(r_board[0], r_board[3], r_board[6]) |
                   line3(r_board[1], r_board[4], r_board[7]) |
                   line3(r_board[2], r_board[5], r_board[8]) |
                   line3(r_board[0], r_board[4], r_board[8]) |
                   line3(r_board[2], r_board[4], r_board[6]);

    assign w_in_range = (bus.move_num >= 4'd1) && (bus.move_num <= 4'd9);
    assign w_idx      = bus.move_num - 4'd1;

    // Current content of the requested square (don't-care when out of range).
    always_comb begin
        w_target = 2'b00;
        for (int unsigned i = 0; i < SQUARES; i++) begin
            if (w_idx == CNT_W'(i)) w_target = r_board[i];
        end
    end

    // Next-state and next-board logic; new_game overrides everything.
    always_comb begin
        w_state_nxt      = r_state;
        w_board_nxt      = r_board;
        w_count_nxt      = r_count;
        w_winner_nxt     = r_winner;
        w_game_over_nxt  = r_game_over;
        w_illegal_nxt    = 1'b0;
        w_mover_comp_nxt = r_mover_comp;
        if (bus.new_game) begin
            w_state_nxt      = w_start_state;
            w_board_nxt      = '{default: 2'b00};
            w_count_nxt      = '0;
            w_winner_nxt     = 2'b00;
            w_game_over_nxt  = 1'b0;
            w_mover_comp_nxt = 1'b0;
        end else begin
            case (r_state)
                PLAYER_TURN, COMPUTER_TURN: begin
                    if (bus.move_valid) begin
                        if (!w_in_range || (w_target != 2'b00)) begin
                            w_illegal_nxt = 1'b1;
                        end else begin
                            for (int unsigned i = 0; i < SQUARES; i++) begin
                                if (w_idx == CNT_W'(i))
                                    w_board_nxt[i] = (r_state == COMPUTER_TURN) ? COMPUTER_CODE : PLAYER_CODE;
                            end
                            w_count_nxt      = r_count + 4'd1;
                            w_mover_comp_nxt = (r_state == COMPUTER_TURN);
                            w_state_nxt      = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (w_win) begin
                        w_state_nxt     = DONE;
                        w_winner_nxt    = r_mover_comp ? 2'b10 : 2'b01;
                        w_game_over_nxt = 1'b1;
                    end else if (r_count == 4'd9) begin
                        w_state_nxt     = DONE;
                        w_winner_nxt    = 2'b11;
                        w_game_over_nxt = 1'b1;
                    end else begin
                        w_state_nxt = r_mover_comp ? PLAYER_TURN : COMPUTER_TURN;
                    end
                end
                DONE: ;
                default: w_state_nxt = PLAYER_TURN;
            endcase
        end
    end

    // State register; turn flags are registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= PLAYER_TURN;
            r_board         <= '{default: 2'b00};
            r_count         <= '0;
            r_winner        <= 2'b00;
            r_game_over     <= 1'b0;
            r_illegal       <= 1'b0;
            r_mover_comp    <= 1'b0;
            r_move_ready    <= 1'b1;
            r_player_play   <= 1'b1;
            r_computer_play <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_board         <= w_board_nxt;
            r_count         <= w_count_nxt;
            r_winner        <= w_winner_nxt;
            r_game_over     <= w_game_over_nxt;
            r_illegal       <= w_illegal_nxt;
            r_mover_comp    <= w_mover_comp_nxt;
            r_move_ready    <= (w_state_nxt == PLAYER_TURN) || (w_state_nxt == COMPUTER_TURN);
            r_player_play   <= (w_state_nxt == PLAYER_TURN);
            r_computer_play <= (w_state_nxt == COMPUTER_TURN);
        end
    end

    assign bus.move_ready    = r_move_ready;
    assign bus.player_play   = r_player_play;
    assign bus.computer_play = r_computer_play;
    assign bus.illegal_move  = r_illegal;
    assign bus.game_over     = r_game_over;
    assign bus.winner        = r_winner;
    assign bus.move_count    = r_count;
    assign bus.pos1          = r_board[0];
    assign bus.pos2          = r_board[1];
    assign bus.pos3          = r_board[2];
    assign bus.pos4          = r_board[3];
    assign bus.pos5          = r_board[4];
    assign bus.pos6          = r_board[5];
    assign bus.pos7          = r_board[6];
    assign bus.pos8          = r_board[7];
    assign bus.pos9          = r_board[8];
endmodule

// File: tb/tb_tictactoe_board_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tictactoe_board_ctrl
// Self-checking bench: directed scenarios plus randomized move streams,
// all compared against a game-rule model kept in the bench.
// ---------------------------------------------------------------------------
module tb_tictactoe_board_ctrl;
    logic clk = 1'b0;
    logic reset;

    tictactoe_board_ctrl_if bus();

    tictactoe_board_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Game model: 0 empty, 1 player, 2 computer; side 0 player, 1 computer.
    int m_board [9];
    int m_side;
    bit m_over;
    int m_winner;
    int m_count;
    bit m_next_comp;

    function automatic bit m_line(int a, int b, int c);
        return m_board[a] != 0 && m_board[a] == m_board[b] && m_board[b] == m_board[c];
    endfunction

    function automatic bit m_any_win();
        bit w = 0;
        for (int r = 0; r < 3; r++) begin
            w |= m_line(3*r, 3*r+1, 3*r+2);
            w |= m_line(r, r+3, r+6);
        end
        w |= m_line(0, 4, 8) | m_line(2, 4, 6);
        return w;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 9; i++) m_board[i] = 0;
        m_count = 0; m_over = 0; m_winner = 0;
    endfunction

    function automatic void m_reset();
        m_clear();
        m_side = 0;
        m_next_comp = 1;
    endfunction

    function automatic void m_new_game();
        m_clear();
`ifdef TTT_ALT_START_EN
        m_side = m_next_comp ? 1 : 0;
        m_next_comp = !m_next_comp;
`else
        m_side = 0;
`endif
    endfunction

    // Returns 1 when the request is rejected as illegal.
    function automatic bit m_apply(int num);
        if (m_over) return 0;
        if (num < 1 || num > 9) return 1;
        if (m_board[num-1] != 0) return 1;
        m_board[num-1] = (m_side == 1) ? 2 : 1;
        m_count++;
        if (m_any_win()) begin
            m_over = 1; m_winner = (m_side == 1) ? 2 : 1;
        end else if (m_count == 9) begin
            m_over = 1; m_winner = 3;
        end else begin
            m_side = 1 - m_side;
        end
        return 0;
    endfunction

    function automatic logic [17:0] dut_board();
        return {bus.pos9, bus.pos8, bus.pos7, bus.pos6, bus.pos5,
                bus.pos4, bus.pos3, bus.pos2, bus.pos1};
    endfunction

    function automatic logic [17:0] exp_board();
        logic [17:0] v;
        for (int i = 0; i < 9; i++) v[2*i +: 2] = 2'(m_board[i]);
        return v;
    endfunction

    // Issue one request held for 'hold' cycles; captures outputs one cycle
    // after the first edge, then returns one further cycle later.
    task automatic send_move(input int num, input int hold,
                             output logic ill_first, output logic ready_first,
                             output logic go_first, output logic [17:0] board_first);
        @(negedge clk);
        bus.move_valid = 1'b1;
        bus.move_num   = 4'(num);
        @(negedge clk);
        ill_first   = bus.illegal_move;
        ready_first = bus.move_ready;
        go_first    = bus.game_over;
        board_first = dut_board();
        if (hold < 2) bus.move_valid = 1'b0;
        @(negedge clk);
        bus.move_valid = 1'b0;
    endtask

    task automatic do_new_game(input bit with_move, input int num);
        @(negedge clk);
        bus.new_game   = 1'b1;
        bus.move_valid = with_move;
        bus.move_num   = 4'(num);
        @(negedge clk);
        bus.new_game   = 1'b0;
        bus.move_valid = 1'b0;
        m_new_game();
    endtask

    task automatic test_reset();
        logic i1, r1, g1; logic [17:0] b1;
        reset = 1'b1;
        bus.new_game = 1'b0; bus.move_valid = 1'b0; bus.move_num = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_reset();
        @(negedge clk);
        checks++; if (dut_board() !== 18'd0) begin errors++; $display("FAIL reset_board: got %h expected 0", dut_board()); end
        checks++; if ({bus.move_count, bus.winner, bus.game_over, bus.illegal_move} !== 8'd0) begin errors++;
            $display("FAIL reset_status: got cnt=%0d win=%0d go=%0b ill=%0b expected all 0", bus.move_count, bus.winner, bus.game_over, bus.illegal_move); end
        checks++; if ({bus.move_ready, bus.player_play, bus.computer_play} !== 3'b110) begin errors++;
            $display("FAIL reset_turn: got %b expected 110", {bus.move_ready, bus.player_play, bus.computer_play}); end
        // Reset asserted during CHECK aborts the game and discards the check.
        send_move(5, 1, i1, r1, g1, b1);
        @(negedge clk);
        bus.move_valid = 1'b1; bus.move_num = 4'd1;
        @(negedge clk);
        bus.move_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (dut_board() !== 18'd0 || bus.move_count !== 4'd0) begin errors++;
            $display("FAIL reset_midgame: got board=%h cnt=%0d expected 0/0", dut_board(), bus.move_count); end
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        @(negedge clk);
        checks++; if ({bus.move_ready, bus.player_play, bus.computer_play} !== 3'b110) begin errors++;
            $display("FAIL reset_midgame_turn: got %b expected 110", {bus.move_ready, bus.player_play, bus.computer_play}); end
    endtask

    task automatic test_player_win();
        int seq [5] = '{1, 4, 2, 5, 3};
        logic i1, r1, g1; logic [17:0] b1;
        bit ei;
        for (int k = 0; k < 5; k++) begin
            send_move(seq[k], 1, i1, r1, g1, b1);
            ei = m_apply(seq[k]);
            checks++; if (i1 !== ei) begin errors++; $display("FAIL win_illegal[%0d]: got %b expected %b", k, i1, ei); end
        end
        checks++; if (g1 !== 1'b0) begin errors++; $display("FAIL win_go_early: got %b expected 0 during CHECK", g1); end
        checks++; if (b1 !== exp_board()) begin errors++; $display("FAIL win_board_next_cycle: got %h expected %h", b1, exp_board()); end
        checks++; if ({bus.pos1, bus.pos2, bus.pos3} !== 6'b010101) begin errors++; $display("FAIL win_row: got %b expected 010101", {bus.pos1, bus.pos2, bus.pos3}); end
        checks++; if ({bus.winner, bus.game_over, bus.move_ready} !== 4'b0110) begin errors++;
            $display("FAIL win_status: got win=%b go=%b rdy=%b expected 01 1 0", bus.winner, bus.game_over, bus.move_ready); end
    endtask

    task automatic test_illegal_occupied();
        logic i1, r1, g1; logic [17:0] b1;
        do_new_game(0, 0);
        send_move(5, 1, i1, r1, g1, b1); void'(m_apply(5));
        // Ensure the computer side is the one requesting the taken square.
        if (m_side == 0) begin send_move(1, 1, i1, r1, g1, b1); void'(m_apply(1)); end
        send_move(5, 1, i1, r1, g1, b1);
        checks++; if (i1 !== (1'b1 ^ m_over)) begin errors++; $display("FAIL occ_pulse: got %b expected 1", i1); end
        checks++; if (bus.illegal_move !== 1'b0) begin errors++; $display("FAIL occ_pulse_len: got %b expected 0", bus.illegal_move); end
        checks++; if (dut_board() !== exp_board() || bus.move_count !== 4'(m_count)) begin errors++;
            $display("FAIL occ_board: got %h cnt=%0d expected %h cnt=%0d", dut_board(), bus.move_count, exp_board(), m_count); end
        checks++; if (bus.computer_play !== 1'b1 || bus.pos5 === 2'b00) begin errors++;
            $display("FAIL occ_turn: got cp=%b pos5=%b expected cp=1 pos5 set", bus.computer_play, bus.pos5); end
    endtask

    task automatic test_out_of_range();
        int bad [2] = '{0, 12};
        logic i1, r1, g1; logic [17:0] b1;
        do_new_game(0, 0);
        for (int k = 0; k < 2; k++) begin
            send_move(bad[k], 1, i1, r1, g1, b1);
            void'(m_apply(bad[k]));
            checks++; if (i1 !== 1'b1) begin errors++; $display("FAIL range_pulse[%0d]: got %b expected 1", bad[k], i1); end
            checks++; if (dut_board() !== exp_board() || bus.move_count !== 4'(m_count) || bus.illegal_move !== 1'b0) begin errors++;
                $display("FAIL range_state[%0d]: got %h cnt=%0d ill=%b expected %h cnt=%0d ill=0", bad[k], dut_board(), bus.move_count, bus.illegal_move, exp_board(), m_count); end
        end
    endtask

    task automatic test_draw();
        int seq [9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
        logic i1, r1, g1; logic [17:0] b1;
        do_new_game(0, 0);
        // Force the player to open so the fixed order yields the draw.
        if (m_side != 0) do_new_game(0, 0);
        for (int k = 0; k < 9; k++) begin
            send_move(seq[k], 1, i1, r1, g1, b1);
            void'(m_apply(seq[k]));
        end
        checks++; if ({bus.winner, bus.move_count, bus.game_over} !== 7'b11_1001_1) begin errors++;
            $display("FAIL draw: got win=%b cnt=%0d go=%b expected 11 9 1", bus.winner, bus.move_count, bus.game_over); end
        checks++; if (dut_board() !== exp_board()) begin errors++; $display("FAIL draw_board: got %h expected %h", dut_board(), exp_board()); end
    endtask

    task automatic test_ignored_moves();
        int seq [4] = '{4, 2, 5, 3};
        logic i1, r1, g1; logic [17:0] b1;
        do_new_game(0, 0);
        if (m_side != 0) do_new_game(0, 0);
        // Held across the CHECK cycle: only one commit, no rejection.
        send_move(1, 2, i1, r1, g1, b1); void'(m_apply(1));
        checks++; if (i1 !== 1'b0 || r1 !== 1'b0 || bus.illegal_move !== 1'b0) begin errors++;
            $display("FAIL check_drop: got ill=%b rdy=%b ill2=%b expected 0 0 0", i1, r1, bus.illegal_move); end
        checks++; if (bus.move_count !== 4'd1 || bus.computer_play !== 1'b1) begin errors++;
            $display("FAIL check_drop_state: got cnt=%0d cp=%b expected 1 1", bus.move_count, bus.computer_play); end
        for (int k = 0; k < 4; k++) begin send_move(seq[k], 1, i1, r1, g1, b1); void'(m_apply(seq[k])); end
        send_move(9, 1, i1, r1, g1, b1); void'(m_apply(9));
        checks++; if (i1 !== 1'b0 || dut_board() !== exp_board() || bus.move_count !== 4'd5 || bus.game_over !== 1'b1) begin errors++;
            $display("FAIL done_drop: got ill=%b board=%h cnt=%0d go=%b expected 0 %h 5 1", i1, dut_board(), bus.move_count, bus.game_over, exp_board()); end
        do_new_game(1, 7);
        checks++; if (dut_board() !== 18'd0 || bus.move_count !== 4'd0 || bus.illegal_move !== 1'b0 || bus.game_over !== 1'b0) begin errors++;
            $display("FAIL newgame_clear: got board=%h cnt=%0d ill=%b go=%b expected 0", dut_board(), bus.move_count, bus.illegal_move, bus.game_over); end
        @(negedge clk);
        checks++; if (bus.illegal_move !== 1'b0 || dut_board() !== 18'd0) begin errors++;
            $display("FAIL newgame_move_discard: got ill=%b board=%h expected 0 0", bus.illegal_move, dut_board()); end
    endtask

    task automatic test_start_side();
        bit exp_cp;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        for (int k = 0; k < 2; k++) begin
            do_new_game(0, 0);
`ifdef TTT_ALT_START_EN
            exp_cp = (k == 0);
`else
            exp_cp = 1'b0;
`endif
            checks++; if ({bus.player_play, bus.computer_play} !== {!exp_cp, exp_cp}) begin errors++;
                $display("FAIL start_side[%0d]: got pp=%b cp=%b expected pp=%b cp=%b", k, bus.player_play, bus.computer_play, !exp_cp, exp_cp); end
        end
    endtask

    task automatic test_random();
        logic i1, r1, g1; logic [17:0] b1;
        int sel, num;
        bit ei;
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 24);
            if (sel == 0) begin
                do_new_game($urandom_range(0, 1), $urandom_range(1, 9));
            end else begin
                num = (sel < 21) ? $urandom_range(1, 9) : ((sel < 24) ? $urandom_range(10, 15) : 0);
                send_move(num, 1, i1, r1, g1, b1);
                ei = m_apply(num);
                checks++; if (i1 !== ei) begin errors++; $display("FAIL rnd_illegal[%0d]: num=%0d got %b expected %b", n, num, i1, ei); end
            end
            checks++; if (dut_board() !== exp_board()) begin errors++; $display("FAIL rnd_board[%0d]: got %h expected %h", n, dut_board(), exp_board()); end
            checks++; if ({bus.move_count, bus.winner, bus.game_over, bus.illegal_move} !== {4'(m_count), 2'(m_winner), m_over, 1'b0}) begin errors++;
                $display("FAIL rnd_status[%0d]: got cnt=%0d win=%0d go=%b ill=%b expected cnt=%0d win=%0d go=%b ill=0",
                         n, bus.move_count, bus.winner, bus.game_over, bus.illegal_move, m_count, m_winner, m_over); end
            checks++; if ({bus.move_ready, bus.player_play, bus.computer_play} !== {!m_over, !m_over && m_side == 0, !m_over && m_side == 1}) begin errors++;
                $display("FAIL rnd_turn[%0d]: got rdy=%b pp=%b cp=%b expected over=%b side=%0d", n, bus.move_ready, bus.player_play, bus.computer_play, m_over, m_side); end
        end
    endtask

    initial begin
        test_reset();
        test_player_win();
        test_illegal_occupied();
        test_out_of_range();
        test_draw();
        test_ignored_moves();
        test_start_side();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
